// File: rtl/cpu_debug_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_debug_ctrl_if
// Register-dump stream between the debug controller and the debug/trace host.
// One beat carries one register: its index, its value, and a last-beat flag.
//
// Signals:
//   out_valid  master->slave  beat valid
//   out_ready  slave->master  host accepts the beat
//   out_idx    master->slave  register index of the beat (5 bits)
//   out_data   master->slave  register value of the beat (32 bits)
//   out_last   master->slave  beat is the final register
// Modports: master (debug controller), slave (host).
// -----------------------------------------------------------------------------
interface cpu_debug_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/cpu_debug_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_debug_ctrl
// Debug/halt controller for the pipelined RISC-V core. Stops the core on a PC
// breakpoint, a run-cycle watchdog or a manual request, lets the pipeline
// drain, streams every register out through the dump interface and then holds
// the core halted until resumed.
//
// Parameters:
//   NREG          registers dumped (indices 0..NREG-1, NREG <= 32)
//   CYCLE_LIMIT   watchdog fires after this many RUN cycles, 0 disables it
//   DRAIN_CYCLES  cycles spent letting EX/MEM/WB retire before the dump
//   CNT_W         width of cycle_cnt (<= 32)
//
// Ports:
//   clk, rstn        clock (rising edge) and asynchronous active-low reset
//   pc, pc_valid     fetch-stage PC and its qualifier
//   bp_en, bp_addr   breakpoint enable and address
//   dump_req         manual halt-and-dump request (level)
//   resume           leave HALT
//   cpu_stall        freezes PC and IF/ID
//   reg_sel/reg_data register-file debug read port (zero-latency read)
//   dump             dump stream, master side
//   halted           controller is in HALT
//   cause            last halt cause: 01 breakpoint, 10 watchdog, 11 manual
//   cycle_cnt        saturating count of RUN cycles since reset or resume
// -----------------------------------------------------------------------------
module cpu_debug_ctrl #(
  parameter int unsigned NREG         = 32,
  parameter int unsigned CYCLE_LIMIT  = 1000,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [31:0]          pc,
  input  logic                 pc_valid,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  input  logic                 dump_req,
  input  logic                 resume,
  output logic                 cpu_stall,
  output logic [4:0]           reg_sel,
  input  logic [31:0]          reg_data,
  cpu_debug_ctrl_if.master     dump,
  output logic                 halted,
  output logic [1:0]           cause,
  output logic [CNT_W-1:0]     cycle_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_t      state;
  logic [4:0]  idx;
  logic        out_valid_q;
  logic        out_last_q;
  logic        bp_armed;
  logic [31:0] drain_cnt;

  logic bp_hit;
  logic wd_hit;
  logic handshake;

  // Trigger decode. The watchdog compares the (possibly saturated) counter
  // zero-extended, so a limit beyond the counter range simply never fires.
  always_comb begin
    bp_hit    = bp_en && pc_valid && (pc == bp_addr) && bp_armed;
    wd_hit    = (CYCLE_LIMIT != 0) && (32'(cycle_cnt) == (CYCLE_LIMIT - 32'd1));
    handshake = out_valid_q && dump.out_ready;
  end

  // Register 0 is hardwired to zero on RISC-V, so beat 0 never trusts the RF.
  always_comb begin
    dump.out_valid = out_valid_q;
    dump.out_idx   = idx;
    dump.out_last  = out_last_q;
    dump.out_data  = (out_valid_q && (idx != 5'd0)) ? reg_data : 32'd0;
    reg_sel        = idx;
  end

  // Main controller: state, stall/halt flags, dump index, cause, cycle counter
  // and breakpoint arming all live in one registered block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RUN;
      cpu_stall   <= 1'b0;
      halted      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      idx         <= 5'd0;
      cause       <= 2'b00;
      cycle_cnt   <= '0;
      bp_armed    <= 1'b1;
      drain_cnt   <= 32'd0;
    end else begin
      // Resume disarms so the core can step off the breakpoint; any fetch at
      // a different PC re-arms it.
      if ((state == HALT) && resume) begin
        bp_armed <= 1'b0;
      end else if (pc_valid && (pc != bp_addr)) begin
        bp_armed <= 1'b1;
      end

      case (state)
        RUN: begin
          if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
          if (bp_hit || wd_hit || dump_req) begin
            cause     <= bp_hit ? 2'b01 : (wd_hit ? 2'b10 : 2'b11);
            cpu_stall <= 1'b1;
            drain_cnt <= 32'd0;
            if (DRAIN_CYCLES == 0) begin
              state       <= DUMP;
              out_valid_q <= 1'b1;
              idx         <= 5'd0;
              out_last_q  <= (NREG == 1);
            end else begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == (DRAIN_CYCLES - 32'd1)) begin
            state       <= DUMP;
            out_valid_q <= 1'b1;
            idx         <= 5'd0;
            out_last_q  <= (NREG == 1);
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end

        DUMP: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
              state       <= HALT;
              halted      <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              idx         <= 5'd0;
            end else begin
              idx        <= idx + 5'd1;
              out_last_q <= ((idx + 5'd1) == LAST_IDX);
            end
          end
        end

        HALT: begin
          if (resume) begin
            state     <= RUN;
            cpu_stall <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
          end
        end

        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_debug_ctrl.md
# cpu_debug_ctrl

Debug/halt controller for the pipelined RISC-V core. It watches the fetch PC and stops the core on one of three triggers: a PC breakpoint, a run-cycle watchdog, or a manual request. It then drains the pipeline and sequences the register-file debug read port (`reg_sel`/`reg_data`) to stream all registers out over a valid/ready interface. The core stays halted until it is resumed. It sits between the core top level and the debug/trace host, replacing the ad-hoc stop-and-dump logic in simulation benches.

## Interface
- `NREG`, 32: registers dumped, indices 0..NREG-1.
- `CYCLE_LIMIT`, 1000: watchdog trigger after this many RUN cycles; 0 disables the watchdog.
- `DRAIN_CYCLES`, 3: cycles spent in DRAIN so in-flight EX/MEM/WB instructions retire.
- `CNT_W`, 16: width of `cycle_cnt`.
- `clk`  in  1  clock, all state on rising edge.
- `rstn`  in  1  reset. Asynchronous, active-low.
- `pc`  in  32  fetch-stage PC.
- `pc_valid`  in  1  `pc` holds a real fetch this cycle.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  32  breakpoint PC.
- `dump_req`  in  1  manual halt-and-dump request, level-sampled.
- `resume`  in  1  leave HALT.
- `cpu_stall`  out  1  freezes PC and IF/ID. Downstream stages keep running and fill with bubbles.
- `reg_sel`  out  5  register-file debug read select.
- `reg_data`  in  32  combinational RF read of `reg_sel`.
- `out_valid`  out  1  dump beat valid.
- `out_ready`  in  1  host accepts beat.
- `out_idx`  out  5  register index of beat.
- `out_data`  out  32  register value of beat.
- `out_last`  out  1  beat is index NREG-1.
- `halted`  out  1  state is HALT.
- `cause`  out  2  last halt cause. 00 none, 01 breakpoint, 10 watchdog, 11 manual.
- `cycle_cnt`  out  CNT_W  RUN cycles since reset or resume. Saturates at all-ones.

## Operation
- States: RUN, DRAIN, DUMP, HALT. Reset enters RUN.
- RUN:
  - `cpu_stall`=0 and `cycle_cnt` increments each cycle.
  - Triggers, in priority order:
    - breakpoint: `bp_en` && `pc_valid` && `pc`==`bp_addr` && `bp_armed`
    - watchdog: `CYCLE_LIMIT`!=0 && `cycle_cnt`==`CYCLE_LIMIT`-1
    - manual: `dump_req`
  - Any trigger moves to DRAIN, loads `cause` with the highest-priority active trigger, and clears the drain counter.
- DRAIN:
  - `cpu_stall`=1 and `cycle_cnt` holds.
  - After `DRAIN_CYCLES` cycles, moves to DUMP with idx=0.
- DUMP:
  - `cpu_stall`=1, `out_valid`=1, `reg_sel`=`out_idx`=idx.
  - `out_data`=`reg_data`, except idx 0 always reports 0.
  - `out_last`=(idx==NREG-1).
  - On `out_valid`&&`out_ready`: idx+1. On the last beat, moves to HALT.
  - While not ready: idx, `reg_sel`, `out_data` stay stable. No beat is dropped or duplicated.
- HALT:
  - `cpu_stall`=1, `halted`=1.
  - `resume` moves to RUN, clears `cycle_cnt` to 0, and clears `bp_armed`. `cause` is retained until the next trigger.
- `bp_armed`:
  - Set to 1 at reset.
  - Cleared on resume.
  - Set again in any cycle with `pc_valid` && `pc`!=`bp_addr`. Stepping off a breakpoint therefore does not retrigger immediately.
- Ignored inputs:
  - `dump_req` outside RUN.
  - `resume` outside HALT.
  - `dump_req` in HALT concurrent with `resume`: resume wins and the request is dropped.
- Width rule: idx is 5 bits and NREG ≤ 32. `cycle_cnt` saturates, never wraps. When `cycle_cnt` is saturated the watchdog compare uses the saturated value.

## Timing
- Reset values while `rstn`=0, asynchronously:
  - state RUN, `cpu_stall`=0, `out_valid`=0, `out_last`=0, `halted`=0.
  - `reg_sel`=0, `out_idx`=0, `out_data`=0, `cause`=00, `cycle_cnt`=0, `bp_armed`=1.
- Reset asserted mid-DUMP or in HALT aborts immediately. After `rstn` rises the core runs unstalled.
- Trigger sampled at edge N: `cpu_stall`=1 from N+1. `cpu_stall` is a registered decode of state, no combinational path from `pc`.
- First `out_valid` at N+1+`DRAIN_CYCLES`.
- With `out_ready` held high, the dump takes exactly NREG cycles. `halted`=1 on the cycle after the last handshake.
- `resume` sampled at edge M: `cpu_stall`=0 and `cycle_cnt`=0 from M+1. Counting restarts at M+1.
- `out_data` is combinational from `reg_data`. The RF debug port must be a zero-latency read.

## Test plan
- Breakpoint: `bp_addr`=0x48, `bp_en`=1, program reaches 0x48.
  - `cause`=01 and stall one cycle after the `pc` match.
  - 32 beats `out_idx` 0..31 with `out_last` only on 31.
  - Beat 0 data = 0. Beats match the RF model. `halted`=1.
- Backpressure: same dump with `out_ready` toggling 1,0,0,1.
  - Beats are held stable while not ready.
  - No duplicated or missing index. Total beats = 32.
- Watchdog: `CYCLE_LIMIT`=10, `bp_en`=0.
  - Trigger at `cycle_cnt`=9, `cause`=10.
  - After `resume`: `cycle_cnt` restarts at 0 and a second halt occurs 10 cycles later.
- Priority: `dump_req`=1 in the same cycle as a breakpoint match gives `cause`=01. `dump_req` during DUMP has no effect.
- Re-arm: resume while `pc`=`bp_addr`.
  - No retrigger while `pc` stays at 0x48.
  - After `pc` leaves and returns to 0x48, a halt occurs.
- Reset mid-DUMP: drop `rstn` at idx=12.
  - Outputs go to reset values immediately. `out_valid`=0.
  - After release, `cpu_stall`=0 and `cycle_cnt` counts from 0.
